// File: rtl/calc_pkg.sv
// Shared definitions for the 4-bit signed calculator: opcodes, error codes
// and the operation sequencer state encoding.
package calc_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_TMO = 2'b01;
    localparam logic [1:0] ERR_RNG = 2'b10;
    localparam logic [1:0] ERR_ILL = 2'b11;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ALU      = 3'd1,
        ISSUE    = 3'd2,
        WAIT_MUL = 3'd3,
        DONE     = 3'd4
    } seq_state_t;

endpackage

// File: rtl/calc_addsub_unit.sv
// Combinational 4-bit signed add/sub producing a sign-extended 8-bit result
// and a flag for results that do not fit back into 4 signed bits.
module calc_addsub_unit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       sub,
    output logic [7:0] sum,
    output logic       out_of_range
);

    logic [7:0] a_ext;
    logic [7:0] b_ext;

    always_comb begin
        a_ext = {{4{a[3]}}, a};
        b_ext = {{4{b[3]}}, b};
        sum   = sub ? (a_ext - b_ext) : (a_ext + b_ext);
        // In -8..+7 exactly when bits 7..3 are all copies of the sign.
        out_of_range = !((sum[7:3] == 5'b00000) || (sum[7:3] == 5'b11111));
    end

endmodule

// File: rtl/calc_op_sequencer.sv
// Accepts one add/sub/mul at a time, computes add/sub locally, dispatches mul
// to the shared multiplier and bounds the wait with a watchdog.
module calc_op_sequencer
    import calc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       op_valid,
    output logic       op_ready,
    input  logic [1:0] op_code,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       mul_start,
    output logic [3:0] mul_a,
    output logic [3:0] mul_b,
    input  logic       mul_done,
    input  logic [7:0] mul_c,
    output logic [7:0] result,
    output logic [1:0] err,
    output logic       result_valid
);

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);

    seq_state_t state_q, state_d;
    logic [1:0] op_q, op_d;
    logic [3:0] mul_a_q, mul_a_d;
    logic [3:0] mul_b_q, mul_b_d;
    logic [7:0] result_q, result_d;
    logic [1:0] err_q, err_d;
    logic [7:0] timer_q, timer_d;

    logic [7:0] addsub_sum;
    logic       addsub_oor;

    // The captured operands feed both the multiplier and the add/sub unit.
    calc_addsub_unit u_addsub (
        .a            (mul_a_q),
        .b            (mul_b_q),
        .sub          (op_q == OP_SUB),
        .sum          (addsub_sum),
        .out_of_range (addsub_oor)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= OP_ADD;
            mul_a_q  <= 4'h0;
            mul_b_q  <= 4'h0;
            result_q <= 8'h00;
            err_q    <= ERR_OK;
            timer_q  <= 8'h00;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
            result_q <= result_d;
            err_q    <= err_d;
            timer_q  <= timer_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        mul_a_d   = mul_a_q;
        mul_b_d   = mul_b_q;
        result_d  = result_q;
        err_d     = err_q;
        timer_d   = timer_q;
        mul_start = 1'b0;

        case (state_q)
            IDLE: begin
                if (op_valid) begin
                    mul_a_d = a;
                    mul_b_d = b;
                    op_d    = op_code;
                    case (op_code)
                        OP_ADD, OP_SUB: state_d = ALU;
                        OP_MUL:         state_d = ISSUE;
                        default: begin
                            result_d = 8'h00;
                            err_d    = ERR_ILL;
                            state_d  = DONE;
                        end
                    endcase
                end
            end
            ALU: begin
                result_d = addsub_sum;
                err_d    = addsub_oor ? ERR_RNG : ERR_OK;
                state_d  = DONE;
            end
            ISSUE: begin
                mul_start = 1'b1;
                timer_d   = 8'h00;
                state_d   = WAIT_MUL;
            end
            WAIT_MUL: begin
                timer_d = timer_q + 8'h01;
                // A completion landing on the last watchdog cycle still counts.
                if (mul_done) begin
                    result_d = mul_c;
                    err_d    = ERR_OK;
                    state_d  = DONE;
                end else if (timer_q == TIMER_LAST) begin
                    result_d = 8'h00;
                    err_d    = ERR_TMO;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign op_ready     = (state_q == IDLE);
    assign result_valid = (state_q == DONE);
    assign mul_a        = mul_a_q;
    assign mul_b        = mul_b_q;
    assign result       = result_q;
    assign err          = err_q;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Scoreboard bench for calc_op_sequencer with a behavioural multiplier whose
// completion delay can be set or disabled per scenario.
module tb_calc_op_sequencer;
    import calc_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       op_valid;
    logic       op_ready;
    logic [1:0] op_code;
    logic [3:0] a;
    logic [3:0] b;
    logic       mul_start;
    logic [3:0] mul_a;
    logic [3:0] mul_b;
    logic       mul_done;
    logic [7:0] mul_c;
    logic [7:0] result;
    logic [1:0] err;
    logic       result_valid;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [7:0] res;
        logic [1:0] err;
        int         lat;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic [1:0] op;
        logic [3:0] av;
        logic [3:0] bv;
        logic [7:0] res;
        logic [1:0] err;
    } alu_vec_t;

    alu_vec_t alu_tbl[7] = '{
        '{OP_ADD, 4'h3, 4'h4, 8'h07, ERR_OK},
        '{OP_SUB, 4'h8, 4'h1, 8'hF7, ERR_RNG},
        '{OP_ADD, 4'h7, 4'h1, 8'h08, ERR_RNG},
        '{OP_SUB, 4'h2, 4'h5, 8'hFD, ERR_OK},
        '{OP_ADD, 4'h8, 4'h8, 8'hF0, ERR_RNG},
        '{OP_SUB, 4'h7, 4'h8, 8'h0F, ERR_RNG},
        '{OP_ADD, 4'hF, 4'h9, 8'hF8, ERR_OK}
    };

    typedef struct {
        int         delay;
        logic [3:0] av;
        logic [3:0] bv;
        logic [7:0] res;
    } mul_vec_t;

    mul_vec_t mul_tbl[4] = '{
        '{9,  4'hD, 4'h5, 8'hF1},
        '{1,  4'h7, 4'h7, 8'h31},
        '{15, 4'h8, 4'h8, 8'h40},
        '{3,  4'h8, 4'h7, 8'hC8}
    };

    calc_op_sequencer #(.TIMEOUT_CYCLES(15)) dut (
        .clk          (clk),
        .rst          (rst),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .op_code      (op_code),
        .a            (a),
        .b            (b),
        .mul_start    (mul_start),
        .mul_a        (mul_a),
        .mul_b        (mul_b),
        .mul_done     (mul_done),
        .mul_c        (mul_c),
        .result       (result),
        .err          (err),
        .result_valid (result_valid)
    );

    always #5 clk = ~clk;

    // Multiplier model: mul_done in the cycle mul_delay after the start pulse.
    int mul_delay = 9;
    bit mul_en    = 1'b1;
    int mul_cnt;

    always @(posedge clk) begin
        if (rst)                     mul_cnt <= 0;
        else if (mul_start && mul_en) mul_cnt <= mul_delay;
        else if (mul_cnt > 0)        mul_cnt <= mul_cnt - 1;
    end

    assign mul_done = (mul_cnt == 1);
    assign mul_c    = {{4{mul_a[3]}}, mul_a} * {{4{mul_b[3]}}, mul_b};

    // Drives one request through the acceptance edge; returns in cycle E0+1.
    task automatic issue(input logic [1:0] oc, input logic [3:0] av, input logic [3:0] bv);
        @(negedge clk);
        vectors++;
        if (op_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL issue_ready: op_ready=%b required 1", op_ready);
        end
        op_valid = 1'b1;
        op_code  = oc;
        a        = av;
        b        = bv;
        @(negedge clk);
        op_valid = 1'b0;
        a        = 4'($urandom);
        b        = 4'($urandom);
    endtask

    // Waits up to 40 cycles for result_valid, tracking mul_start pulses and
    // operand stability; pops the scoreboard entry on completion.
    task automatic wait_result(input int inject_at, input logic [3:0] ea, input logic [3:0] eb,
                               input bit chk_ab, output int lat, output int starts,
                               output bit ab_ok, output bit seen, output exp_t e);
        lat    = 1;
        starts = 0;
        ab_ok  = 1'b1;
        seen   = 1'b0;
        e      = '{res: 8'hxx, err: 2'bxx, lat: -1};
        while (lat <= 40 && !seen) begin
            if (mul_start === 1'b1) starts++;
            if (chk_ab && (mul_a !== ea || mul_b !== eb)) ab_ok = 1'b0;
            if (result_valid === 1'b1) begin
                seen = 1'b1;
                if (sb_q.size() > 0) e = sb_q.pop_front();
            end else begin
                op_valid = (lat == inject_at);
                op_code  = OP_ADD;
                a        = 4'h1;
                b        = 4'h1;
                @(negedge clk);
                lat++;
            end
        end
        op_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        op_valid = 1'b0;
        op_code  = OP_ADD;
        a        = 4'h0;
        b        = 4'h0;
        repeat (3) @(negedge clk);
        vectors++;
        if (op_ready !== 1'b1 || result_valid !== 1'b0 || mul_start !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: ready/valid/start=%b%b%b required 100", op_ready, result_valid, mul_start);
        end
        vectors++;
        if (result !== 8'h00 || err !== ERR_OK || mul_a !== 4'h0 || mul_b !== 4'h0) begin
            miscompares++;
            $display("FAIL reset_data: result=%h err=%b mul_a=%h mul_b=%h required 00 00 0 0", result, err, mul_a, mul_b);
        end
        rst = 1'b0;
    endtask

    task automatic test_alu();
        int lat, starts;
        bit ab_ok, seen;
        exp_t e;
        foreach (alu_tbl[i]) begin
            sb_q.push_back('{res: alu_tbl[i].res, err: alu_tbl[i].err, lat: 2});
            issue(alu_tbl[i].op, alu_tbl[i].av, alu_tbl[i].bv);
            wait_result(0, alu_tbl[i].av, alu_tbl[i].bv, 1'b1, lat, starts, ab_ok, seen, e);
            vectors++;
            if (!seen || lat !== e.lat) begin
                miscompares++;
                $display("FAIL alu%0d_latency: got E0+%0d required E0+%0d", i, lat, e.lat);
            end
            vectors++;
            if (result !== e.res || err !== e.err) begin
                miscompares++;
                $display("FAIL alu%0d_value: result=%h err=%b required %h %b", i, result, err, e.res, e.err);
            end
            vectors++;
            if (starts !== 0 || !ab_ok) begin
                miscompares++;
                $display("FAIL alu%0d_side: mul_start pulses=%0d ab_stable=%b required 0 1", i, starts, ab_ok);
            end
            @(negedge clk);
            vectors++;
            if (op_ready !== 1'b1 || result_valid !== 1'b0 || result !== e.res) begin
                miscompares++;
                $display("FAIL alu%0d_after: ready=%b valid=%b result=%h required 1 0 %h", i, op_ready, result_valid, result, e.res);
            end
        end
    endtask

    task automatic test_mul();
        int lat, starts;
        bit ab_ok, seen;
        exp_t e;
        foreach (mul_tbl[i]) begin
            mul_delay = mul_tbl[i].delay;
            sb_q.push_back('{res: mul_tbl[i].res, err: ERR_OK, lat: 2 + mul_tbl[i].delay});
            issue(OP_MUL, mul_tbl[i].av, mul_tbl[i].bv);
            wait_result(0, mul_tbl[i].av, mul_tbl[i].bv, 1'b1, lat, starts, ab_ok, seen, e);
            vectors++;
            if (!seen || lat !== e.lat) begin
                miscompares++;
                $display("FAIL mul%0d_latency: got E0+%0d required E0+%0d", i, lat, e.lat);
            end
            vectors++;
            if (result !== e.res || err !== e.err) begin
                miscompares++;
                $display("FAIL mul%0d_value: result=%h err=%b required %h %b", i, result, err, e.res, e.err);
            end
            vectors++;
            if (starts !== 1 || !ab_ok) begin
                miscompares++;
                $display("FAIL mul%0d_handshake: mul_start pulses=%0d ab_stable=%b required 1 1", i, starts, ab_ok);
            end
            @(negedge clk);
        end
        mul_delay = 9;
    endtask

    task automatic test_timeout();
        int lat, starts;
        bit ab_ok, seen;
        exp_t e;
        mul_en = 1'b0;
        sb_q.push_back('{res: 8'h00, err: ERR_TMO, lat: 17});
        issue(OP_MUL, 4'h2, 4'h3);
        wait_result(0, 4'h2, 4'h3, 1'b1, lat, starts, ab_ok, seen, e);
        vectors++;
        if (!seen || lat !== e.lat) begin
            miscompares++;
            $display("FAIL timeout_latency: got E0+%0d required E0+%0d", lat, e.lat);
        end
        vectors++;
        if (result !== e.res || err !== e.err) begin
            miscompares++;
            $display("FAIL timeout_value: result=%h err=%b required %h %b", result, err, e.res, e.err);
        end
        @(negedge clk);
        vectors++;
        if (op_ready !== 1'b1 || result_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_ready: ready=%b valid=%b at E0+18 required 1 0", op_ready, result_valid);
        end
        mul_en = 1'b1;
    endtask

    task automatic test_illegal();
        int lat, starts;
        bit ab_ok, seen;
        exp_t e;
        sb_q.push_back('{res: 8'h00, err: ERR_ILL, lat: 1});
        issue(OP_ILL, 4'h5, 4'h5);
        wait_result(0, 4'h5, 4'h5, 1'b0, lat, starts, ab_ok, seen, e);
        vectors++;
        if (!seen || lat !== e.lat) begin
            miscompares++;
            $display("FAIL illegal_latency: got E0+%0d required E0+%0d", lat, e.lat);
        end
        vectors++;
        if (result !== e.res || err !== e.err || starts !== 0) begin
            miscompares++;
            $display("FAIL illegal_value: result=%h err=%b starts=%0d required %h %b 0", result, err, starts, e.res, e.err);
        end
        @(negedge clk);
    endtask

    task automatic test_ignore_during_mul();
        int lat, starts, extra;
        bit ab_ok, seen;
        exp_t e;
        sb_q.push_back('{res: 8'hF1, err: ERR_OK, lat: 11});
        issue(OP_MUL, 4'hD, 4'h5);
        wait_result(4, 4'hD, 4'h5, 1'b1, lat, starts, ab_ok, seen, e);
        vectors++;
        if (!seen || lat !== e.lat || result !== e.res || err !== e.err) begin
            miscompares++;
            $display("FAIL ignore_result: lat=E0+%0d result=%h err=%b required E0+%0d %h %b", lat, result, err, e.lat, e.res, e.err);
        end
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (result_valid === 1'b1) extra++;
        end
        vectors++;
        if (extra !== 0) begin
            miscompares++;
            $display("FAIL ignore_extra: extra result_valid=%0d required 0", extra);
        end
    endtask

    task automatic test_reset_mid_mul();
        int lat, starts, extra;
        bit ab_ok, seen;
        exp_t e;
        issue(OP_MUL, 4'h6, 4'h3);
        repeat (4) @(negedge clk);  // now in WAIT_MUL cycle 4
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (op_ready !== 1'b1 || result_valid !== 1'b0 || result !== 8'h00 || err !== ERR_OK) begin
            miscompares++;
            $display("FAIL midreset_state: ready=%b valid=%b result=%h err=%b required 1 0 00 00", op_ready, result_valid, result, err);
        end
        vectors++;
        if (mul_a !== 4'h0 || mul_b !== 4'h0) begin
            miscompares++;
            $display("FAIL midreset_operands: mul_a=%h mul_b=%h required 0 0", mul_a, mul_b);
        end
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (result_valid === 1'b1) extra++;
        end
        vectors++;
        if (extra !== 0) begin
            miscompares++;
            $display("FAIL midreset_valid: result_valid count=%0d required 0", extra);
        end
        sb_q.push_back('{res: 8'h04, err: ERR_OK, lat: 2});
        issue(OP_ADD, 4'h2, 4'h2);
        wait_result(0, 4'h2, 4'h2, 1'b1, lat, starts, ab_ok, seen, e);
        vectors++;
        if (!seen || lat !== e.lat || result !== e.res || err !== e.err) begin
            miscompares++;
            $display("FAIL midreset_add: lat=E0+%0d result=%h err=%b required E0+%0d %h %b", lat, result, err, e.lat, e.res, e.err);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mul();
        test_timeout();
        test_illegal();
        test_ignore_during_mul();
        test_reset_mid_mul();
        vectors++;
        if (sb_q.size() !== 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left required 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/calc_op_sequencer.md
# calc_op_sequencer

Operation sequencer for the 4-bit signed calculator datapath. It accepts one operation at a time (add, sub, mul) on two 4-bit two's-complement operands. Add/sub is computed in-block; mul is dispatched to the shared shift-add multiplier using a one-cycle start pulse, with operands held stable until it reports done. Every operation returns one sign-extended 8-bit result plus an error code, and a watchdog bounds the multiplier wait.

## Interface
- TIMEOUT_CYCLES, 15: maximum WAIT_MUL cycles before declaring timeout (must be ≥10, ≤255)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- op_valid  in  1  operation request
- op_ready  out  1  sequencer idle, request accepted when op_valid & op_ready
- op_code  in  2  00 add, 01 sub, 10 mul, 11 illegal
- a  in  4  operand A, signed
- b  in  4  operand B, signed
- mul_start  out  1  one-cycle start pulse to multiplier
- mul_a  out  4  registered operand A to multiplier
- mul_b  out  4  registered operand B to multiplier
- mul_done  in  1  multiplier completion pulse
- mul_c  in  8  multiplier product, valid while mul_done=1
- result  out  8  signed result, held until next completion
- err  out  2  00 ok, 01 mul timeout, 10 add/sub out of 4-bit range, 11 illegal opcode
- result_valid  out  1  one-cycle completion strobe

## Operation
- States: IDLE, ALU, ISSUE, WAIT_MUL, DONE. op_ready = (state==IDLE); result_valid = (state==DONE).
- IDLE: on op_valid, register a, b, op_code into mul_a, mul_b, op_q.
  - 00/01 → ALU.
  - 10 → ISSUE.
  - 11 → DONE with result=0x00, err=11.
  - op_valid while not IDLE is ignored (not queued).
- ALU: result = sext8(A) ± sext8(B); err=10 if result outside −8..+7, else 00. → DONE.
- ISSUE: mul_start=1 (only state driving it); timer cleared. → WAIT_MUL.
- WAIT_MUL: timer increments each cycle.
  - mul_done=1: result=mul_c, err=00, → DONE.
  - Else if timer==TIMEOUT_CYCLES−1: result=0x00, err=01, → DONE.
  - If mul_done coincides with the timeout cycle, mul_done wins.
- DONE: result_valid=1 for exactly one cycle. → IDLE.
- mul_done outside WAIT_MUL is ignored.
- mul_a/mul_b are constant from acceptance until return to IDLE; the multiplier samples them every cycle of its run.
- Product range −56..+64 always fits 8 bits; no range error on mul.
- Reset (any state, including mid-WAIT_MUL): next edge state=IDLE, result=0x00, err=00, mul_a=mul_b=0, timer=0. No result_valid is produced for the aborted op. The multiplier shares rst.

## Timing
- Reset values: op_ready=1, result_valid=0, mul_start=0, result=0x00, err=00, mul_a=mul_b=0x0.
- Acceptance at edge E0:
  - add/sub: result_valid in cycle E0+2.
  - illegal: result_valid in cycle E0+1.
  - mul: mul_start high in cycle E0+1. If mul_done arrives in WAIT_MUL cycle k (k=1 first), result_valid is in cycle E0+2+k.
  - mul timeout: result_valid in cycle E0+TIMEOUT_CYCLES+2.
- The nominal multiplier raises mul_done 9 cycles after the start pulse, giving result_valid at E0+11.
- result/err update on the edge entering DONE. op_ready rises the cycle after DONE, so back-to-back ops are spaced ≥1 idle cycle.

## Structure
- Shared package calc_pkg holds:
  - opcode constants OP_ADD, OP_SUB, OP_MUL, OP_ILL
  - error codes ERR_OK, ERR_TMO, ERR_RNG, ERR_ILL
  - state enum seq_state_t
- Natural sub-module: calc_addsub_unit, combinational. Inputs: 4-bit a, b, sub. Outputs: 8-bit sext sum and range flag. The FSM, timer and output registers stay in calc_op_sequencer.

## Test plan
- Add a=3, b=4 → result_valid at E0+2, result=0x07, err=00, mul_start never asserted.
- Sub a=0x8 (−8), b=1 → result=0xF7, err=10.
- Mul a=0xD (−3), b=5; model asserts mul_done with mul_c=0xF1 nine cycles after mul_start:
  - exactly one mul_start pulse
  - mul_a=0xD and mul_b=0x5 stable throughout
  - result=0xF1, err=00, result_valid at E0+11
- Mul with mul_done never asserted, TIMEOUT_CYCLES=15 → result=0x00, err=01, result_valid at E0+17, op_ready back at E0+18.
- op_code=11 → result=0x00, err=11 at E0+1, no mul_start. A second op_valid pulse during a mul is ignored (single result_valid).
- rst asserted in WAIT_MUL cycle 4 → next cycle IDLE, op_ready=1, result=0x00, no result_valid; a subsequent add 2+2 returns 0x04.
